// File: rtl/proj_pkg.sv
// Shared constants, types and helpers for the FM genome buffer and its controller.
package proj_pkg;

  localparam int FM_RAMS_COUNT                = 2;
  localparam int FM_ENTRIES_COUNT             = 2;
  localparam int FM_OFFSET_COUNT              = 4;
  localparam int FM_EXTENDER_BYTES_READ_COUNT = 4;
  localparam int FM_REQUESTERS_COUNT          = 4;

  localparam int FM_BUFFER_SIZE = FM_RAMS_COUNT * FM_ENTRIES_COUNT * FM_OFFSET_COUNT;
  localparam int FM_ADDR_BITS   = $clog2(FM_BUFFER_SIZE);

  typedef logic [FM_ADDR_BITS-1:0] fm_addr_t;

  typedef enum logic [1:0] {
    FILL_FIRST = 2'd0,
    STREAM     = 2'd1,
    STALL      = 2'd2
  } fm_ctrl_state_e;

  // Index width for n lanes, never narrower than one bit.
  function automatic int fm_idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/proj_fm_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant and index, pointer advances past each winner.
module proj_fm_rr_arbiter
  import proj_pkg::*;
#(
  parameter int  REQUESTERS = 4,
  localparam int IDX_W      = fm_idx_bits(REQUESTERS)
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic [REQUESTERS-1:0] in_req,
  input  logic                  in_en,
  output logic [REQUESTERS-1:0] out_grant,
  output logic [IDX_W-1:0]      out_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] lane;
  logic             found;

  always_comb begin
    out_grant = '0;
    out_idx   = '0;
    found     = 1'b0;
    lane      = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      lane = IDX_W'((int'(ptr_q) + i) % REQUESTERS);
      if (!found && in_en && in_req[lane]) begin
        found           = 1'b1;
        out_grant[lane] = 1'b1;
        out_idx         = lane;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (int'(out_idx) == REQUESTERS - 1) ? '0 : out_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/proj_fm_ctrl.sv
// Ping-pong FM genome buffer controller: fills one bank while extender lanes read the other.
//
// state      | meaning
// FILL_FIRST | first bank filling, nothing readable yet
// STREAM     | filling one bank, lanes read the other
// STALL      | filling bank full, waiting for readers to release
module proj_fm_ctrl
  import proj_pkg::*;
#(
  parameter int  REQUESTERS = FM_REQUESTERS_COUNT,
  parameter int  BANK_SIZE  = FM_BUFFER_SIZE,
  parameter int  READ_BYTES = FM_EXTENDER_BYTES_READ_COUNT,
  localparam int ADDR_BITS  = $clog2(BANK_SIZE),
  localparam int ID_BITS    = fm_idx_bits(REQUESTERS)
) (
  input  logic                            in_clk,
  input  logic                            in_rst,
  input  logic                            in_wr_valid,
  output logic                            out_wr_ready,
  output logic                            out_wr_en,
  output logic [ADDR_BITS-1:0]            out_wr_addr,
  output logic                            out_wr_bank,
  input  logic [REQUESTERS-1:0]           in_req_valid,
  input  logic [REQUESTERS*ADDR_BITS-1:0] in_req_addr,
  output logic [REQUESTERS-1:0]           out_req_grant,
  output logic                            out_rd_en,
  output logic [ADDR_BITS-1:0]            out_rd_addr,
  output logic                            out_rd_bank,
  output logic                            out_rd_valid,
  output logic [ID_BITS-1:0]              out_rd_id,
  input  logic                            in_rd_release,
  output logic                            out_rd_bank_valid,
  output logic                            out_swap
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR  = ADDR_BITS'(BANK_SIZE - 1);
  localparam logic [ADDR_BITS-1:0] ALIGN_MASK = ~(ADDR_BITS'(READ_BYTES - 1));

  fm_ctrl_state_e         state_q, state_d;
  logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
  logic                   wr_bank_q, wr_bank_d;
  logic                   release_pend_q, release_pend_d;
  logic [REQUESTERS-1:0]  grant_q, grant_d;
  logic                   rd_en_q, rd_en_d;
  logic [ADDR_BITS-1:0]   rd_addr_q, rd_addr_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [ID_BITS-1:0]     issue_id_q, issue_id_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [ID_BITS-1:0]     rd_id_q, rd_id_d;
  logic                   swap_q, swap_d;

  logic                   wr_ready, wr_en, wr_last, release_now, rd_bank_cur, do_swap;
  logic                   arb_en;
  logic [REQUESTERS-1:0]  arb_grant;
  logic [ID_BITS-1:0]     arb_idx;
  logic [ADDR_BITS-1:0]   req_addr [REQUESTERS];

  for (genvar g = 0; g < REQUESTERS; g++) begin : g_addr
    assign req_addr[g] = in_req_addr[g*ADDR_BITS +: ADDR_BITS];
  end

  assign arb_en = (state_q != FILL_FIRST);

  proj_fm_rr_arbiter #(.REQUESTERS(REQUESTERS)) u_arb (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_req   (in_req_valid),
    .in_en    (arb_en),
    .out_grant(arb_grant),
    .out_idx  (arb_idx)
  );

  always_comb begin
    wr_ready    = (state_q != STALL);
    wr_en       = in_wr_valid & wr_ready;
    wr_last     = wr_en && (wr_addr_q == LAST_ADDR);
    release_now = release_pend_q | in_rd_release;
    rd_bank_cur = (state_q == FILL_FIRST) ? 1'b0 : ~wr_bank_q;
    do_swap     = 1'b0;
    state_d     = state_q;
    case (state_q)
      FILL_FIRST: begin
        if (wr_last) begin
          do_swap = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (wr_last) begin
          if (release_now) do_swap = 1'b1;
          else             state_d = STALL;
        end
      end
      STALL: begin
        if (release_now) begin
          do_swap = 1'b1;
          state_d = STREAM;
        end
      end
      default: state_d = FILL_FIRST;
    endcase
  end

  always_comb begin
    wr_addr_d      = wr_en ? wr_addr_q + 1'b1 : wr_addr_q;
    wr_bank_d      = do_swap ? ~wr_bank_q : wr_bank_q;
    // A release landing in the swap cycle is consumed by that swap.
    release_pend_d = do_swap ? 1'b0
                   : (release_pend_q | (in_rd_release & (state_q != FILL_FIRST)));
    swap_d         = do_swap;
    grant_d        = arb_grant;
    rd_en_d        = |arb_grant;
    rd_addr_d      = rd_addr_q;
    rd_bank_d      = rd_bank_q;
    issue_id_d     = issue_id_q;
    if (|arb_grant) begin
      rd_addr_d  = req_addr[arb_idx] & ALIGN_MASK;
      rd_bank_d  = rd_bank_cur;
      issue_id_d = arb_idx;
    end
    rd_valid_d = rd_en_q;
    rd_id_d    = rd_en_q ? issue_id_q : '0;
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q        <= FILL_FIRST;
      wr_addr_q      <= '0;
      wr_bank_q      <= 1'b0;
      release_pend_q <= 1'b0;
      grant_q        <= '0;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      rd_bank_q      <= 1'b0;
      issue_id_q     <= '0;
      rd_valid_q     <= 1'b0;
      rd_id_q        <= '0;
      swap_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_addr_q      <= wr_addr_d;
      wr_bank_q      <= wr_bank_d;
      release_pend_q <= release_pend_d;
      grant_q        <= grant_d;
      rd_en_q        <= rd_en_d;
      rd_addr_q      <= rd_addr_d;
      rd_bank_q      <= rd_bank_d;
      issue_id_q     <= issue_id_d;
      rd_valid_q     <= rd_valid_d;
      rd_id_q        <= rd_id_d;
      swap_q         <= swap_d;
    end
  end

  assign out_wr_ready      = wr_ready;
  assign out_wr_en         = wr_en;
  assign out_wr_addr       = wr_addr_q;
  assign out_wr_bank       = wr_bank_q;
  assign out_req_grant     = grant_q;
  assign out_rd_en         = rd_en_q;
  assign out_rd_addr       = rd_addr_q;
  assign out_rd_bank       = rd_bank_q;
  assign out_rd_valid      = rd_valid_q;
  assign out_rd_id         = rd_id_q;
  assign out_rd_bank_valid = (state_q != FILL_FIRST);
  assign out_swap          = swap_q;

endmodule

// File: tb/tb_proj_fm_ctrl.sv
// Directed bench for proj_fm_ctrl with BANK_SIZE=16, READ_BYTES=4, four lanes.
module tb_proj_fm_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready, wr_en, wr_bank;
  logic [3:0]  wr_addr;
  logic [3:0]  req_valid;
  logic [15:0] req_addr;
  logic [3:0]  grant;
  logic        rd_en, rd_bank, rd_valid, rd_release, bank_valid, swap;
  logic [3:0]  rd_addr;
  logic [1:0]  rd_id;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  proj_fm_ctrl dut (
    .in_clk           (clk),
    .in_rst           (rst),
    .in_wr_valid      (wr_valid),
    .out_wr_ready     (wr_ready),
    .out_wr_en        (wr_en),
    .out_wr_addr      (wr_addr),
    .out_wr_bank      (wr_bank),
    .in_req_valid     (req_valid),
    .in_req_addr      (req_addr),
    .out_req_grant    (grant),
    .out_rd_en        (rd_en),
    .out_rd_addr      (rd_addr),
    .out_rd_bank      (rd_bank),
    .out_rd_valid     (rd_valid),
    .out_rd_id        (rd_id),
    .in_rd_release    (rd_release),
    .out_rd_bank_valid(bank_valid),
    .out_swap         (swap)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] rd_addr;
    logic       rd_valid;
    logic [1:0] rd_id;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Lane addresses: 5->4, 10->8, 13->12, 3->0 after window alignment.
    req_addr = {4'd3, 4'd13, 4'd10, 4'd5};
    // Round-robin pointer is at lane 1 when the table starts.
    vecs[0]  = '{4'b1111, 4'b0010, 4'd8,  1'b0, 2'd0};
    vecs[1]  = '{4'b1111, 4'b0100, 4'd12, 1'b1, 2'd1};
    vecs[2]  = '{4'b1111, 4'b1000, 4'd0,  1'b1, 2'd2};
    vecs[3]  = '{4'b1111, 4'b0001, 4'd4,  1'b1, 2'd3};
    vecs[4]  = '{4'b1111, 4'b0010, 4'd8,  1'b1, 2'd0};
    vecs[5]  = '{4'b0000, 4'b0000, 4'd0,  1'b1, 2'd1};
    vecs[6]  = '{4'b0100, 4'b0100, 4'd12, 1'b0, 2'd0};
    vecs[7]  = '{4'b0000, 4'b0000, 4'd0,  1'b1, 2'd2};
    vecs[8]  = '{4'b0000, 4'b0000, 4'd0,  1'b0, 2'd0};
    vecs[9]  = '{4'b0011, 4'b0001, 4'd4,  1'b0, 2'd0};
    vecs[10] = '{4'b0011, 4'b0010, 4'd8,  1'b1, 2'd0};
    vecs[11] = '{4'b1001, 4'b1000, 4'd0,  1'b1, 2'd1};
    vecs[12] = '{4'b1001, 4'b0001, 4'd4,  1'b1, 2'd3};
    vecs[13] = '{4'b0000, 4'b0000, 4'd0,  1'b1, 2'd0};
    vecs[14] = '{4'b0000, 4'b0000, 4'd0,  1'b0, 2'd0};

    rst = 1'b1; wr_valid = 1'b1; req_valid = '0; rd_release = 1'b0;
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_swap", swap, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_wr_en", wr_en, 1);
    chk("rst_bank_valid", bank_valid, 0);
    chk("rst_rd_addr", rd_addr, 0);
    wr_valid = 1'b0;
    step(); step();
    rst = 1'b0;

    // First fill with lane 0 requesting throughout.
    req_valid = 4'b0001; wr_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("fill1_wr_addr", wr_addr, k);
      chk("fill1_no_grant", grant, 0);
      chk("fill1_bank_invalid", bank_valid, 0);
      step();
    end
    chk("fill1_swap", swap, 1);
    chk("fill1_wr_bank", wr_bank, 1);
    chk("fill1_bank_valid", bank_valid, 1);
    chk("fill1_grant_late", grant, 0);
    chk("fill1_wr_addr_wrap", wr_addr, 0);
    wr_valid = 1'b0;
    step();
    chk("first_grant", grant, 4'b0001);
    chk("first_rd_en", rd_en, 1);
    chk("first_rd_bank", rd_bank, 0);
    chk("first_rd_addr", rd_addr, 4);
    chk("first_swap_pulse", swap, 0);
    req_valid = '0;
    step();
    chk("first_no_grant", grant, 0);
    chk("first_rd_valid", rd_valid, 1);
    chk("first_rd_id", rd_id, 0);

    // Round-robin and alignment table.
    for (int i = 0; i < 15; i++) begin
      req_valid = vecs[i].req;
      step();
      chk("tbl_grant", grant, vecs[i].grant);
      chk("tbl_rd_en", rd_en, |vecs[i].grant);
      if (|vecs[i].grant) begin
        chk("tbl_rd_addr", rd_addr, vecs[i].rd_addr);
        chk("tbl_rd_bank", rd_bank, 0);
      end
      chk("tbl_rd_valid", rd_valid, vecs[i].rd_valid);
      if (vecs[i].rd_valid) chk("tbl_rd_id", rd_id, vecs[i].rd_id);
    end

    // Second bank filled with no release -> stall, grants continue.
    req_valid = 4'b0001; wr_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("fill2_wr_addr", wr_addr, k);
      chk("fill2_wr_ready", wr_ready, 1);
      step();
    end
    chk("stall_wr_ready", wr_ready, 0);
    chk("stall_wr_en", wr_en, 0);
    chk("stall_no_swap", swap, 0);
    chk("stall_wr_addr", wr_addr, 0);
    chk("stall_wr_bank", wr_bank, 1);
    chk("stall_grant", grant, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stall_hold_ready", wr_ready, 0);
      chk("stall_hold_grant", grant, 4'b0001);
      chk("stall_hold_rd_bank", rd_bank, 0);
    end
    rd_release = 1'b1;
    step();
    rd_release = 1'b0;
    chk("unstall_swap", swap, 1);
    chk("unstall_wr_ready", wr_ready, 1);
    chk("unstall_wr_bank", wr_bank, 0);
    chk("swap_cycle_rd_bank", rd_bank, 0);
    chk("swap_cycle_grant", grant, 4'b0001);
    step();
    chk("post_swap_rd_bank", rd_bank, 1);
    chk("post_swap_pulse_end", swap, 0);
    chk("post_swap_wr_addr", wr_addr, 1);

    // Early release during the third fill -> swap at the end without stalling.
    req_valid = '0;
    for (int k = 1; k < 16; k++) begin
      rd_release = (k == 3);
      chk("early_wr_ready", wr_ready, 1);
      chk("early_wr_addr", wr_addr, k);
      step();
    end
    rd_release = 1'b0;
    chk("early_swap", swap, 1);
    chk("early_wr_bank", wr_bank, 1);
    chk("early_wr_ready_end", wr_ready, 1);
    step();
    chk("early_ready_after", wr_ready, 1);
    chk("early_wr_addr_after", wr_addr, 1);
    chk("early_swap_end", swap, 0);

    // Fourth fill without release must stall (pending release was consumed).
    req_valid = 4'b0001;
    for (int k = 1; k < 16; k++) step();
    chk("fill4_stall", wr_ready, 0);
    chk("fill4_grant", grant, 4'b0001);
    chk("fill4_rd_en", rd_en, 1);

    // Asynchronous reset between edges with a read in flight.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_rd_en", rd_en, 0);
    chk("arst_rd_valid", rd_valid, 0);
    chk("arst_wr_ready", wr_ready, 1);
    chk("arst_bank_valid", bank_valid, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_wr_bank", wr_bank, 0);
    step();
    rst = 1'b0;
    wr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_rd_valid", rd_valid, 0);
      chk("post_rst_grant", grant, 0);
    end
    wr_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("refill_no_grant", grant, 0);
      chk("refill_wr_addr", wr_addr, k);
      step();
    end
    chk("refill_swap", swap, 1);
    wr_valid = 1'b0;
    step();
    chk("refill_grant", grant, 4'b0001);
    chk("refill_rd_bank", rd_bank, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
